display_msg_ctrl: RTL and testbench

Message sequencer that sits directly upstream of the six-digit HEX message memory and drives its displayAddr/modo inputs.
- Before and during a game, it shows the current level ("nivel N").
- When the game ends, it blinks the result ("venceu"/"perdeu") a fixed number of times, then holds it steady until cleared.
- Blank phases use address 2'b11, which the message memory renders as all segments off.

---
 rtl/display_pkg.sv | 26 ++
 rtl/blink_timer.sv | 50 +++++
 rtl/display_msg_ctrl.sv | 175 +++++++++++++++++
 tb/tb_display_msg_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the HEX message path.
// Holds the message-memory address map and the sequencer state encoding so the
// controller and the message memory agree on both from a single source.
package display_pkg;

  // Message memory address map.
  localparam logic [1:0] ADDR_NIVEL   = 2'b00;
  localparam logic [1:0] ADDR_VENCEU  = 2'b01;
  localparam logic [1:0] ADDR_PERDEU  = 2'b10;
  localparam logic [1:0] ADDR_APAGADO = 2'b11;  // all segments off

  // Sequencer states; values double as the debug LED encoding.
  typedef enum logic [2:0] {
    StNivel   = 3'd0,
    StJogo    = 3'd1,
    StResOn   = 3'd2,
    StResOff  = 3'd3,
    StResHold = 3'd4
  } state_e;

  // Address of the result message: lose selects "perdeu", otherwise "venceu".
  function automatic logic [1:0] res_addr(input logic lose);
    return lose ? ADDR_PERDEU : ADDR_VENCEU;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink phase timer.
// Counts enabled cycles from 0 to BLINK_CYCLES-1, then restarts at 0. tc_o is
// high during the last cycle of a phase, so each phase lasts exactly
// BLINK_CYCLES enabled cycles. clr_i has priority over en_i.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   clr_i   - synchronous clear of the phase count
//   en_i    - count enable
//   tc_o    - terminal count (last cycle of the current phase)
module blink_timer #(
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned PW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [PW-1:0] PhaseLast = PW'(BLINK_CYCLES - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == PhaseLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == PhaseLast) begin
        cnt_d = '0;
      end else if (cnt_q < PhaseLast) begin
        // Guarded increment: the count can never run past the last value.
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_msg_ctrl.sv
// Message sequencer in front of the six-digit HEX message memory.
// Shows the level while idle or playing, blinks the game result BLINK_TIMES
// on/off pairs of BLINK_CYCLES cycles each, then holds the result until clear.
// All outputs are registered and change on the same edge as the state.
// Ports:
//   clock       - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   modo_in     - level selected by the player
//   jogando     - game in progress (level)
//   venceu      - game won (single-cycle pulse)
//   perdeu      - game lost (single-cycle pulse, wins over venceu)
//   clear       - return to level display (single-cycle pulse, top priority)
//   displayAddr - message select to the message memory
//   modo        - level digit to the message memory
//   busy        - high while the result is blinking
//   db_estado   - current state encoding for debug LEDs
module display_msg_ctrl
  import display_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES = 25000000,
  parameter int unsigned BLINK_TIMES  = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] modo_in,
  input  logic       jogando,
  input  logic       venceu,
  input  logic       perdeu,
  input  logic       clear,
  output logic [1:0] displayAddr,
  output logic [1:0] modo,
  output logic       busy,
  output logic [2:0] db_estado
);

  localparam int unsigned BW = $clog2(BLINK_TIMES + 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_TIMES - 1);

  state_e        state_q, state_d;
  logic          res_q, res_d;      // 1: lose, 0: win
  logic [1:0]    level_q, level_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [1:0]    addr_q, addr_d;
  logic [1:0]    modo_q, modo_d;
  logic          busy_q, busy_d;

  logic phase_en, phase_clr, phase_tc;

  assign phase_en  = (state_q == StResOn) || (state_q == StResOff);
  // Holding the timer in clear outside the blink keeps every blink phase
  // starting from zero.
  assign phase_clr = clear || !phase_en;

  blink_timer #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blink_timer (
    .clk_i (clock),
    .rst_ni(reset_n),
    .clr_i (phase_clr),
    .en_i  (phase_en),
    .tc_o  (phase_tc)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    level_d = level_q;
    blink_d = blink_q;
    if (clear) begin
      state_d = StNivel;
      res_d   = 1'b0;
      blink_d = '0;
    end else begin
      unique case (state_q)
        StNivel: begin
          if (jogando) begin
            state_d = StJogo;
            level_d = modo_in;
          end
        end
        StJogo: begin
          if (perdeu) begin
            state_d = StResOn;
            res_d   = 1'b1;
            blink_d = '0;
          end else if (venceu) begin
            state_d = StResOn;
            res_d   = 1'b0;
            blink_d = '0;
          end else if (!jogando) begin
            state_d = StNivel;
          end
        end
        StResOn: begin
          if (phase_tc) begin
            state_d = StResOff;
          end
        end
        StResOff: begin
          if (phase_tc) begin
            if (blink_q == BlinkLast) begin
              state_d = StResHold;
            end else begin
              state_d = StResOn;
              blink_d = blink_q + BW'(1);
            end
          end
        end
        StResHold: begin
          state_d = StResHold;
        end
        default: begin
          state_d = StNivel;
        end
      endcase
    end
  end

  // Output values are derived from the next state so they register on the
  // same edge as the state itself.
  always_comb begin
    addr_d = ADDR_NIVEL;
    modo_d = level_d;
    busy_d = 1'b0;
    unique case (state_d)
      StNivel: begin
        modo_d = modo_in;
      end
      StJogo: begin
        modo_d = level_d;
      end
      StResOn: begin
        addr_d = res_addr(res_d);
        busy_d = 1'b1;
      end
      StResOff: begin
        addr_d = ADDR_APAGADO;
        busy_d = 1'b1;
      end
      StResHold: begin
        addr_d = res_addr(res_d);
      end
      default: begin
        addr_d = ADDR_NIVEL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StNivel;
      res_q   <= 1'b0;
      level_q <= 2'b00;
      blink_q <= '0;
      addr_q  <= ADDR_NIVEL;
      modo_q  <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      level_q <= level_d;
      blink_q <= blink_d;
      addr_q  <= addr_d;
      modo_q  <= modo_d;
      busy_q  <= busy_d;
    end
  end

  assign displayAddr = addr_q;
  assign modo        = modo_q;
  assign busy        = busy_q;
  assign db_estado   = state_q;

endmodule

// File: tb/tb_display_msg_ctrl.sv
// Self-checking bench for display_msg_ctrl with BLINK_CYCLES=4, BLINK_TIMES=2.
// The reference model tracks a mode (level/game/blink/hold) and the elapsed
// blink time; on/off phase is derived arithmetically from that time.
module tb_display_msg_ctrl;

  localparam int unsigned C = 4;
  localparam int unsigned T = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] modo_in;
  logic       jogando, venceu, perdeu, clear;
  logic [1:0] displayAddr, modo;
  logic       busy;
  logic [2:0] db_estado;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: mode 0 level, 1 game, 2 blinking, 3 hold.
  int         m_mode, m_t;
  logic [1:0] m_level, m_modo;
  logic       m_lose;
  logic [1:0] e_addr, e_modo;
  logic       e_busy;
  logic [2:0] e_db;

  display_msg_ctrl #(
    .BLINK_CYCLES(C),
    .BLINK_TIMES (T)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .modo_in    (modo_in),
    .jogando    (jogando),
    .venceu     (venceu),
    .perdeu     (perdeu),
    .clear      (clear),
    .displayAddr(displayAddr),
    .modo       (modo),
    .busy       (busy),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  task automatic model_expect();
    logic on;
    e_addr = 2'b00;
    e_modo = m_level;
    e_busy = 1'b0;
    e_db   = 3'd0;
    case (m_mode)
      0: e_modo = m_modo;
      1: e_db = 3'd1;
      2: begin
        on     = ((m_t / C) % 2) == 0;
        e_addr = on ? (m_lose ? 2'b10 : 2'b01) : 2'b11;
        e_busy = 1'b1;
        e_db   = on ? 3'd2 : 3'd3;
      end
      default: begin
        e_addr = m_lose ? 2'b10 : 2'b01;
        e_db   = 3'd4;
      end
    endcase
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_t     = 0;
    m_level = 2'b00;
    m_modo  = 2'b00;
    m_lose  = 1'b0;
    model_expect();
  endtask

  task automatic model_step(input logic [1:0] mi, input logic j, input logic v,
                            input logic p, input logic c);
    if (c) begin
      m_mode = 0;
      m_t    = 0;
      m_modo = mi;
    end else begin
      case (m_mode)
        0: begin
          m_modo = mi;
          if (j) begin
            m_mode  = 1;
            m_level = mi;
          end
        end
        1: begin
          if (p || v) begin
            m_mode = 2;
            m_t    = 0;
            m_lose = p;
          end else if (!j) begin
            m_mode = 0;
            m_modo = mi;
          end
        end
        2: begin
          m_t++;
          if (m_t == int'(2 * C * T)) m_mode = 3;
        end
        default: m_mode = 3;
      endcase
    end
    model_expect();
  endtask

  // Drive one cycle of inputs, advance the model and the DUT, sample at +1.
  task automatic tick(input logic [1:0] mi, input logic j, input logic v,
                      input logic p, input logic c);
    modo_in = mi;
    jogando = j;
    venceu  = v;
    perdeu  = p;
    clear   = c;
    model_step(mi, j, v, p, c);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({displayAddr, modo, busy, db_estado} !== 8'b00_00_0_000) begin
      n_fail++;
      $display("FAIL reset_initial got addr=%b modo=%b busy=%b db=%0d want 00/00/0/0",
               displayAddr, modo, busy, db_estado);
    end
    tick(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (displayAddr !== 2'b01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_preblink got addr=%b busy=%b want 01/1", displayAddr, busy);
    end
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({displayAddr, modo, busy, db_estado} !== 8'b00_00_0_000) begin
      n_fail++;
      $display("FAIL reset_async got addr=%b modo=%b busy=%b db=%0d want 00/00/0/0",
               displayAddr, modo, busy, db_estado);
    end
    @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_level_tracking();
    tick(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (modo !== 2'd2 || displayAddr !== 2'b00 || modo !== e_modo) begin
      n_fail++;
      $display("FAIL level_follow got modo=%0d addr=%b want modo=2 addr=00", modo, displayAddr);
    end
    tick(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (modo !== 2'd3 || db_estado !== 3'd1 || displayAddr !== 2'b00 || modo !== e_modo) begin
      n_fail++;
      $display("FAIL level_latched got modo=%0d db=%0d addr=%b want modo=3 db=1 addr=00",
               modo, db_estado, displayAddr);
    end
  endtask

  task automatic test_win_blink();
    logic [2:0] seq[$];
    logic [2:0] exp_seq[5];
    logic [1:0] exp_addr;
    int busy_cnt;
    int bad;
    exp_seq  = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd4};
    busy_cnt = 0;
    bad      = 0;
    tick(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      exp_addr = (i >= 16) ? 2'b01 : (((i / 4) % 2 == 0) ? 2'b01 : 2'b11);
      n_tests++;
      if (displayAddr !== exp_addr || modo !== 2'd2 ||
          {displayAddr, modo, busy, db_estado} !== {e_addr, e_modo, e_busy, e_db}) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL win_seq i=%0d got addr=%b modo=%0d busy=%b db=%0d want addr=%b modo=2",
                   i, displayAddr, modo, busy, db_estado, exp_addr);
      end
      if (busy === 1'b1) busy_cnt++;
      if (seq.size() == 0 || seq[$] != db_estado) seq.push_back(db_estado);
      tick(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_tests++;
    if (busy_cnt != 16) begin
      n_fail++;
      $display("FAIL win_busy_len got %0d cycles want 16", busy_cnt);
    end
    n_tests++;
    if (seq.size() != 5 || seq[0] != exp_seq[0] || seq[1] != exp_seq[1] ||
        seq[2] != exp_seq[2] || seq[3] != exp_seq[3] || seq[4] != exp_seq[4]) begin
      n_fail++;
      $display("FAIL win_db_seq got %0d distinct states want sequence 2,3,2,3,4", seq.size());
    end
  endtask

  task automatic test_simultaneous();
    tick(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (displayAddr !== 2'b10 || db_estado !== 3'd2 || displayAddr !== e_addr) begin
      n_fail++;
      $display("FAIL simul_lose got addr=%b db=%0d want addr=10 db=2", displayAddr, db_estado);
    end
    repeat (18) tick(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (displayAddr !== 2'b10 || db_estado !== 3'd4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_hold got addr=%b db=%0d busy=%b want 10/4/0",
               displayAddr, db_estado, busy);
    end
    tick(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (displayAddr !== 2'b00 || db_estado !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_in_nivel got addr=%b db=%0d busy=%b want 00/0/0",
               displayAddr, db_estado, busy);
    end
  endtask

  task automatic test_clear_at_tc();
    int busy_cnt;
    busy_cnt = 0;
    tick(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (15) tick(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (db_estado !== 3'd3 || displayAddr !== 2'b11 || db_estado !== e_db) begin
      n_fail++;
      $display("FAIL clear_pre got db=%0d addr=%b want db=3 addr=11", db_estado, displayAddr);
    end
    tick(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (displayAddr !== 2'b00 || busy !== 1'b0 || db_estado !== 3'd0) begin
      n_fail++;
      $display("FAIL clear_at_tc got addr=%b busy=%b db=%0d want 00/0/0",
               displayAddr, busy, db_estado);
    end
    tick(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) busy_cnt++;
      tick(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    n_tests++;
    if (busy_cnt != 16 || db_estado !== 3'd4 || displayAddr !== 2'b01) begin
      n_fail++;
      $display("FAIL clear_fresh got busy=%0d db=%0d addr=%b want busy=16 db=4 addr=01",
               busy_cnt, db_estado, displayAddr);
    end
  endtask

  task automatic test_abort();
    tick(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (db_estado !== 3'd0 || modo !== 2'd0 || displayAddr !== 2'b00) begin
      n_fail++;
      $display("FAIL abort got db=%0d modo=%0d addr=%b want 0/0/00", db_estado, modo, displayAddr);
    end
    tick(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (modo !== 2'd3 || modo !== e_modo) begin
      n_fail++;
      $display("FAIL abort_follow got modo=%0d want 3", modo);
    end
  endtask

  task automatic test_random();
    int bad;
    logic [1:0] mi;
    logic j, v, p, c;
    bad = 0;
    tick(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      mi = 2'($urandom_range(0, 3));
      j  = ($urandom_range(0, 11) != 0);
      v  = ($urandom_range(0, 5) == 0);
      p  = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 39) == 0);
      tick(mi, j, v, p, c);
      n_tests++;
      if ({displayAddr, modo, busy, db_estado} !== {e_addr, e_modo, e_busy, e_db}) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL random i=%0d got addr=%b modo=%0d busy=%b db=%0d want %b/%0d/%b/%0d",
                   i, displayAddr, modo, busy, db_estado, e_addr, e_modo, e_busy, e_db);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    modo_in = 2'd0;
    jogando = 1'b0;
    venceu  = 1'b0;
    perdeu  = 1'b0;
    clear   = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_level_tracking();
    test_win_blink();
    test_simultaneous();
    test_clear_at_tc();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
